// File: rtl/io_port_bridge.sv
// External-side bridge for the CPU parallel I/O ports: an RX FIFO feeds in_port, a TX FIFO captures out_port writes.
// Optional IO_BRIDGE_STATUS_EN: when RX is empty, cpu_in_data returns a status word instead of zero.
module io_port_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          clear,
  input  logic [31:0]   ext_rx_data,
  input  logic          ext_rx_valid,
  output logic          ext_rx_ready,
  output logic [31:0]   cpu_in_data,
  input  logic          cpu_in_rd,
  input  logic [31:0]   cpu_out_data,
  input  logic          cpu_out_wr,
  output logic [31:0]   ext_tx_data,
  output logic          ext_tx_valid,
  input  logic          ext_tx_ready,
  output logic [AW:0]   rx_count,
  output logic [AW:0]   tx_count,
  output logic          rx_underflow,
  output logic          tx_overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   rx_mem [DEPTH];
  logic [31:0]   tx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic          wr_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop, tx_drop;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_COUNT);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FULL_COUNT);

  assign ext_rx_ready = !rx_full && !clear;
  assign rx_push      = ext_rx_valid && ext_rx_ready;
  assign rx_pop       = cpu_in_rd && !rx_empty;

  // A pop in the same cycle frees a slot, so a capture into a full TX FIFO still lands.
  assign ext_tx_valid = !tx_empty;
  assign tx_pop       = ext_tx_valid && ext_tx_ready;
  assign tx_push      = wr_d && (!tx_full || tx_pop);
  assign tx_drop      = wr_d && tx_full && !tx_pop;

  assign ext_tx_data = tx_empty ? 32'h0 : tx_mem[tx_rd_ptr];

`ifdef IO_BRIDGE_STATUS_EN
  assign cpu_in_data = rx_empty
    ? {1'b1, 15'b0, tx_overflow, rx_underflow, {(14-(AW+1)){1'b0}}, tx_count}
    : rx_mem[rx_rd_ptr];
`else
  assign cpu_in_data = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
`endif

  // Storage carries no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= ext_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= cpu_out_data;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      rx_count     <= '0;
      tx_count     <= '0;
      wr_d         <= 1'b0;
      rx_underflow <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      wr_d <= cpu_out_wr;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);

      if (rx_push && !rx_pop)      rx_count <= rx_count + (AW+1)'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - (AW+1)'(1);

      if (tx_push && !tx_pop)      tx_count <= tx_count + (AW+1)'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - (AW+1)'(1);

      if (cpu_in_rd && rx_empty) rx_underflow <= 1'b1;
      if (tx_drop)               tx_overflow  <= 1'b1;
    end
  end

endmodule

// File: doc/io_port_bridge.md
# io_port_bridge

External-side peer of the CPU datapath's parallel I/O ports. It feeds words from an external producer into the CPU's input port and captures every CPU write to the output port for delivery to an external consumer. Both directions are buffered in small FIFOs with valid/ready handshakes on the external side. It sits between the top-level pins or the testbench and the datapath's `in_port_data_in` and `out_port_data_out`.

## Interface
- `DEPTH`, 4: entries per FIFO; must be a power of two, at least 2.
- `AW`, 2: pointer width; equals log2(`DEPTH`).

- `clock` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `ext_rx_data` in 32: word offered by the external producer.
- `ext_rx_valid` in 1: producer has a word.
- `ext_rx_ready` out 1: bridge accepts the word this cycle.
- `cpu_in_data` out 32: drives datapath `in_port_data_in`.
- `cpu_in_rd` in 1: one-cycle pulse; the CPU's in-port register loads at the end of this cycle.
- `cpu_out_data` in 32: from datapath `out_port_data_out`.
- `cpu_out_wr` in 1: one-cycle pulse, concurrent with the CPU's out-port register enable.
- `ext_tx_data` out 32: head word of the TX FIFO.
- `ext_tx_valid` out 1: TX FIFO not empty.
- `ext_tx_ready` in 1: consumer takes the word.
- `rx_count` out AW+1: RX occupancy, 0..DEPTH.
- `tx_count` out AW+1: TX occupancy, 0..DEPTH.
- `rx_underflow` out 1: sticky; set by `cpu_in_rd` while RX is empty.
- `tx_overflow` out 1: sticky; set when a captured CPU write was dropped.

## Operation
- **RX FIFO (external → CPU)**
  - Push when `ext_rx_valid && ext_rx_ready`.
  - `ext_rx_ready` = !full && !`clear`.
  - Pop when `cpu_in_rd` and not empty.
  - `cpu_in_data` = head entry when not empty, otherwise the empty value (see Configuration).
- **TX FIFO (CPU → external)**
  - The out-port register updates at the edge ending the `cpu_out_wr` cycle, so the bridge registers `cpu_out_wr` into `wr_d`.
  - In the cycle where `wr_d`=1, the bridge pushes `cpu_out_data` into TX.
  - Pop when `ext_tx_valid && ext_tx_ready`.
- **Simultaneous push and pop on one FIFO:** both take effect and the count is unchanged.
  - RX full: no push occurs because ready=0, even if a pop happens in the same cycle.
  - TX full with a pop and a capture in the same cycle: the capture succeeds and there is no overflow.
- **Capture into a full TX FIFO with no pop:** the word is discarded and `tx_overflow` is set.
- **`cpu_in_rd` on an empty RX FIFO:** no pointer change and `rx_underflow` is set.
- Sticky flags clear only on `clear`.
- Pointers are AW bits and wrap modulo `DEPTH`. Counts are AW+1 bits.
- Back-to-back `cpu_out_wr` pulses are allowed; each one captures the word present one cycle later.

## Timing
- **Reset (`clear`=1, asynchronous):**
  - Pointers, counts, `wr_d` and the sticky flags are all 0.
  - `ext_rx_ready`=0, `ext_tx_valid`=0, `ext_tx_data`=0.
  - `cpu_in_data` = empty value.
- **`clear` asserted mid-operation:** all buffered words are lost, including a pending `wr_d` capture.
- **RX latency:** a word pushed at edge N is visible on `cpu_in_data` after edge N. The CPU may read it with `cpu_in_rd` in cycle N+1.
- **TX latency:** `cpu_out_wr` in cycle N gives a push at edge N+2, so `ext_tx_valid` is high from cycle N+2.
- **Output sourcing:**
  - All outputs are derived from registered state; there is no combinational path from inputs to outputs.
  - Exception: `ext_rx_ready` depends on `clear`.

## Configuration
- **`IO_BRIDGE_STATUS_EN` defined:** when RX is empty, `cpu_in_data` = {1'b1, 15'b0, `tx_overflow`, `rx_underflow`, 14'b0 padding with `tx_count` in bits [AW:0]}. This lets software poll port status through the input port.
- **Not defined:** when RX is empty, `cpu_in_data` = 32'h0000_0000.
- **Either way:** when RX is not empty, `cpu_in_data` is the head word, so bit 31 of a status word can collide with real data. Software must pair status reads with `rx_count` awareness.

## Test plan
- **Reset defaults:** assert `clear` mid-transfer, release it → all counts 0, flags 0, `ext_tx_valid`=0, `ext_rx_ready`=1 one cycle after release.
- **RX ordering:** push 32'hA5A5_0001..32'hA5A5_0004 (DEPTH=4) → `ext_rx_ready` drops after the 4th push. Four `cpu_in_rd` pulses see 0001, 0002, 0003, 0004 in order, then the empty value.
- **RX underflow:** `cpu_in_rd` with RX empty → `rx_underflow`=1, `rx_count` stays 0. With `IO_BRIDGE_STATUS_EN`, `cpu_in_data`=32'h8000_4000.
- **TX capture latency:** `cpu_out_wr` in cycle N, with `cpu_out_data`=32'h0000_1234 in cycle N+1 → `ext_tx_valid`=1 and `ext_tx_data`=32'h0000_1234 in cycle N+2.
- **TX overflow:** `ext_tx_ready`=0, five back-to-back writes of 1..5 → `tx_count`=4 and `tx_overflow`=1. Draining yields 1, 2, 3, 4.
- **Full-FIFO simultaneous push/pop:** TX full, with a capture and `ext_tx_ready`=1 in the same cycle → `tx_count` stays 4 and `tx_overflow` stays 0.
